// File: rtl/fp_add_sequencer_if.sv
// Handshake bundle between the operand source, the FP32 add sequencer and the result consumer.
// The master side drives operands and out_ready; the slave side is the sequencer.
interface fp_add_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/fp_add_sequencer.sv
// Multi-cycle FP32 adder: IDLE -> ALIGN -> ADD -> NORM -> DONE, one operation in flight.
// Truncating arithmetic, denormals flushed to zero, fixed four-cycle latency.
module mantissa_positioner (
  input  logic [24:0] m,
  output logic [22:0] r,
  output logic [4:0]  e
);
  // e counts leading zeros so the top set bit lands in bit 24; r is the bits below it.
  always_comb begin
    e = 5'd0;
    for (int i = 0; i <= 24; i++) begin
      if (m[i]) e = 5'(24 - i);
    end
    r = 23'((m << e) >> 1);
  end
endmodule

module fp_add_sequencer (
  input logic               clk,
  input logic               rst,
  fp_add_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        ready_q;
  logic        busy_q;
  logic        valid_q;
  logic [31:0] result_q;

  logic        sign_l;
  logic        sub_op;
  logic        special;
  logic [7:0]  exp_l;
  logic [23:0] man_l;
  logic [23:0] man_s;
  logic [31:0] special_val;
  logic [24:0] sum;

  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [7:0]  exp_big;
  logic [7:0]  exp_small;
  logic [7:0]  diff;
  logic [22:0] frac_a;
  logic [22:0] frac_b;
  logic [23:0] man_a;
  logic [23:0] man_b;
  logic [23:0] man_small;
  logic [23:0] shifted;
  logic        nan_a;
  logic        nan_b;
  logic        inf_a;
  logic        inf_b;
  logic        a_big;
  logic        spec_hit;
  logic [31:0] spec_val;

  logic [22:0]       norm_frac;
  logic [4:0]        norm_shift;
  logic signed [9:0] exp_r;
  logic [31:0]       norm_result;

  assign bus.in_ready   = ready_q;
  assign bus.busy       = busy_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;

  // Unpack both captured operands, order by magnitude and align the smaller one.
  always_comb begin
    exp_a     = a_q[30:23];
    exp_b     = b_q[30:23];
    frac_a    = (exp_a == 8'd0) ? 23'd0 : a_q[22:0];
    frac_b    = (exp_b == 8'd0) ? 23'd0 : b_q[22:0];
    man_a     = {exp_a != 8'd0, frac_a};
    man_b     = {exp_b != 8'd0, frac_b};
    nan_a     = (exp_a == 8'hFF) && (frac_a != 23'd0);
    nan_b     = (exp_b == 8'hFF) && (frac_b != 23'd0);
    inf_a     = (exp_a == 8'hFF) && (frac_a == 23'd0);
    inf_b     = (exp_b == 8'hFF) && (frac_b == 23'd0);
    a_big     = {exp_a, frac_a} >= {exp_b, frac_b};
    exp_big   = a_big ? exp_a : exp_b;
    exp_small = a_big ? exp_b : exp_a;
    man_small = a_big ? man_b : man_a;
    diff      = exp_big - exp_small;
    shifted   = (diff >= 8'd25) ? 24'd0 : (man_small >> diff[4:0]);
    spec_hit  = nan_a | nan_b | inf_a | inf_b;
    if (nan_a || nan_b || (inf_a && inf_b && (a_q[31] != b_q[31])))
      spec_val = 32'h7FC00000;
    else if (inf_a)
      spec_val = {a_q[31], 8'hFF, 23'd0};
    else
      spec_val = {b_q[31], 8'hFF, 23'd0};
  end

  mantissa_positioner u_norm (
    .m (sum),
    .r (norm_frac),
    .e (norm_shift)
  );

  // Final result selection; specials and exact cancellation take priority over range checks.
  always_comb begin
    exp_r = $signed({2'b00, exp_l}) + 10'sd1 - $signed({5'b00000, norm_shift});
    if (special)
      norm_result = special_val;
    else if (sum == 25'd0)
      norm_result = 32'h00000000;
    else if (exp_r >= 10'sd255)
      norm_result = {sign_l, 8'hFF, 23'd0};
    else if (exp_r <= 10'sd0)
      norm_result = {sign_l, 31'd0};
    else
      norm_result = {sign_l, exp_r[7:0], norm_frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= 32'h00000000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= ALIGN;
          end
        end
        ALIGN: begin
          sign_l      <= a_big ? a_q[31] : b_q[31];
          sub_op      <= a_q[31] ^ b_q[31];
          exp_l       <= exp_big;
          man_l       <= a_big ? man_a : man_b;
          man_s       <= shifted;
          special     <= spec_hit;
          special_val <= spec_val;
          state       <= ADD;
        end
        ADD: begin
          sum   <= sub_op ? ({1'b0, man_l} - {1'b0, man_s}) : ({1'b0, man_l} + {1'b0, man_s});
          state <= NORM;
        end
        NORM: begin
          result_q <= norm_result;
          valid_q  <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/fp_add_sequencer.md
# fp_add_sequencer

Multi-cycle FP32 adder controller that accepts one operand pair over a valid/ready handshake and sequences it through unpack/align, add, normalize and pack states. Normalization reuses the team's combinational leading-zero normalizer, `mantissa_positioner`:
- Input: 25-bit magnitude `m`.
- Outputs: 23-bit fraction `r` and 5-bit left-shift count `e`.

The block sits between an operand source and a result consumer. It is not pipelined and holds one operation in flight at a time.

## Interface
- No parameters; the format is fixed at IEEE-754 binary32 layout.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block idle and accepting; equals (state == IDLE)
- in_a  in  32  operand A, binary32
- in_b  in  32  operand B, binary32
- out_valid  out  1  result present; held until accepted
- out_ready  in  1  consumer accepts result
- out_result  out  32  binary32 sum; registered
- busy  out  1  state != IDLE

## Operation
**States:** IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE. All transitions are unconditional except the following:
- IDLE -> ALIGN on in_valid & in_ready. in_a and in_b are captured at that edge.
- DONE -> IDLE on out_ready.

**ALIGN:**
- Unpack each operand into sign, 8-bit exponent and 24-bit mantissa {hidden, frac}.
- Exponent 0 means zero; denormals are flushed to zero with sign kept.
- Order the operands by magnitude {exp, frac}; the larger is L.
- Right-shift the smaller mantissa by expL - expS. A shift of 25 or more gives 0.
- Shifted-out bits are discarded: no guard, round or sticky bits.
- Classify specials:
  - Either input NaN, or inf + (-inf): result 0x7FC00000.
  - Otherwise, either input inf: that inf.

**ADD:**
- Same signs: m = mL + mS, 25 bits, carry in bit 24.
- Different signs: m = mL - mS, which is never negative.
- Result sign = sign of L.

**NORM:**
- Feed m to the normalizer.
- exp_r = expL + 1 - e, computed in 10-bit signed arithmetic.
- Final result, highest priority first:
  1. Special classification from ALIGN.
  2. m == 0: +0 (0x00000000), including x + (-x) and (-0) + (-0) -> +0.
  3. exp_r >= 255: {sign, 0xFF, 0}, i.e. signed inf (overflow).
  4. exp_r <= 0: {sign, 31'b0}, i.e. signed zero (underflow flush).
  5. Otherwise: {sign, exp_r[7:0], r}.
- The result is registered into out_result at the NORM -> DONE edge.

**Rounding:** truncation only. Results are bit-exact to the algorithm above, not to IEEE round-to-nearest.

**DONE:**
- out_valid = 1.
- out_result and out_valid stay stable until the out_ready handshake.
- in_valid is ignored while not in IDLE.

## Timing
**Reset:**
- rst high at an edge forces, at that edge: state IDLE, out_valid 0, out_result 0x00000000, busy 0, in_ready 1.
- Inputs are ignored while rst is high; reset takes priority over any handshake.
- Reset mid-operation discards the operation with no output.

**Latency:** accept edge T -> state ALIGN in cycle T+1, ADD in T+2, NORM in T+3. out_valid is 1 from the edge ending T+3, i.e. visible in cycle T+4. Latency is fixed at 4 cycles for all inputs, including specials.

**Handshake:**
- Output accepted at the edge where out_valid & out_ready; out_valid is 0 and in_ready is 1 in the following cycle.
- Next accept is possible one cycle after that, so minimum issue interval is 5 cycles.
- out_ready asserted before DONE has no effect.

**Boundaries:**
- in_valid held continuously: exactly one accept per IDLE visit.
- in_a and in_b may change after the accept edge without affecting the result.

## Test plan
- 0x3F800000 + 0x3F800000 accepted at T -> out_result 0x40000000, out_valid first high in cycle T+4, in_ready 0 during T+1..T+4.
- 0x3F800000 + 0xBF400000 (1.0 - 0.75) -> 0x3E800000 (normalizer shift 3); 0x3F800000 + 0xBF800000 -> 0x00000000.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; 0x7F800000 + 0xFF800000 -> 0x7FC00000; 0x00400000 (denormal) + 0x3F800000 -> 0x3F800000.
- out_ready low for 3 cycles in DONE while in_valid high with new operands -> out_result and out_valid stable, no accept. After out_ready: one idle cycle with in_ready 1, then the new operation is accepted.
- rst pulsed for one cycle while state is ADD -> next cycle out_valid 0, out_result 0, in_ready 1, no result emitted. A following 0x40400000 + 0x40000000 -> 0x40A00000.
- 0x4B800000 + 0x33800000 (2^24 + 2^-24, exponent difference 48) -> 0x4B800000 (small operand discarded).
